// File: rtl/jellyvl_synctimer_pkg.sv
// Shared types, constants and step helpers for the synctimer subsystem.
// Users of the functions pass their own numerator/denominator parameters.
package jellyvl_synctimer_pkg;

  localparam int DEFAULT_TIMER_WIDTH = 64;

  typedef logic [DEFAULT_TIMER_WIDTH-1:0] t_time;

  localparam logic ADJ_SIGN_PLUS  = 1'b0;
  localparam logic ADJ_SIGN_MINUS = 1'b1;

  function automatic int calc_step_int(input int numerator, input int denominator);
    return numerator / denominator;
  endfunction

  function automatic int calc_step_frac(input int numerator, input int denominator);
    return numerator % denominator;
  endfunction

  // One extra bit keeps frac + STEP_FRAC (< 2*denominator) from overflowing.
  function automatic int calc_frac_width(input int denominator);
    return $clog2(denominator) + 1;
  endfunction

endpackage

// File: rtl/jellyvl_synctimer_timer_step.sv
// Rational-rate step generator: emits STEP_INT or STEP_INT+1 per cycle so the
// long-run average step equals PERIOD_NUMERATOR / PERIOD_DENOMINATOR.
module jellyvl_synctimer_timer_step
  import jellyvl_synctimer_pkg::*;
#(
  parameter int PERIOD_NUMERATOR   = 10,
  parameter int PERIOD_DENOMINATOR = 3,
  parameter int STEP_WIDTH         = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  output logic [STEP_WIDTH-1:0] step
);

  localparam int FRAC_WIDTH = calc_frac_width(PERIOD_DENOMINATOR);
  localparam logic [FRAC_WIDTH-1:0] STEP_FRAC =
    FRAC_WIDTH'(calc_step_frac(PERIOD_NUMERATOR, PERIOD_DENOMINATOR));
  localparam logic [FRAC_WIDTH-1:0] DENOM = FRAC_WIDTH'(PERIOD_DENOMINATOR);
  localparam logic [STEP_WIDTH-1:0] STEP_INT =
    STEP_WIDTH'(calc_step_int(PERIOD_NUMERATOR, PERIOD_DENOMINATOR));

  logic [FRAC_WIDTH-1:0] frac_q;
  logic [FRAC_WIDTH-1:0] frac_d;
  logic [FRAC_WIDTH-1:0] frac_sum;
  logic                  carry;

  always_comb begin
    frac_sum = frac_q + STEP_FRAC;
    carry    = (frac_sum >= DENOM);
    frac_d   = carry ? (frac_sum - DENOM) : frac_sum;
    if (clear) begin
      frac_d = '0;
    end
    step = STEP_INT + STEP_WIDTH'(carry);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      frac_q <= '0;
    end else begin
      frac_q <= frac_d;
    end
  end

endmodule

// File: rtl/jellyvl_synctimer_timer.sv
// Local free-running timestamp: rational-period advance, +/-1 adjust handshake
// with optional hold-off, absolute load, and saturating adjust statistics.
module jellyvl_synctimer_timer
  import jellyvl_synctimer_pkg::*;
#(
  parameter int                     TIMER_WIDTH        = 64,
  parameter int                     PERIOD_NUMERATOR   = 10,
  parameter int                     PERIOD_DENOMINATOR = 3,
  parameter int                     ADJUST_HOLD        = 0,
  parameter int                     COUNT_WIDTH        = 16,
  parameter logic [TIMER_WIDTH-1:0] INIT_TIME          = '0
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic [TIMER_WIDTH-1:0] set_time,
  input  logic                   set_valid,
  input  logic                   adjust_sign,
  input  logic                   adjust_valid,
  output logic                   adjust_ready,
  output logic [TIMER_WIDTH-1:0] current_time,
  output logic [COUNT_WIDTH-1:0] adjust_plus_count,
  output logic [COUNT_WIDTH-1:0] adjust_minus_count
);

  localparam int HOLD_WIDTH = (ADJUST_HOLD > 0) ? $clog2(ADJUST_HOLD + 1) : 1;
  localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD = HOLD_WIDTH'(ADJUST_HOLD);

  logic [TIMER_WIDTH-1:0] time_q,  time_d;
  logic [HOLD_WIDTH-1:0]  hold_q,  hold_d;
  logic [COUNT_WIDTH-1:0] plus_q,  plus_d;
  logic [COUNT_WIDTH-1:0] minus_q, minus_d;
  logic [TIMER_WIDTH-1:0] step;
  logic [TIMER_WIDTH-1:0] adj_delta;
  logic                   accept;

  jellyvl_synctimer_timer_step #(
    .PERIOD_NUMERATOR  (PERIOD_NUMERATOR),
    .PERIOD_DENOMINATOR(PERIOD_DENOMINATOR),
    .STEP_WIDTH        (TIMER_WIDTH)
  ) u_step (
    .clk  (clk),
    .reset(reset),
    .clear(set_valid),
    .step (step)
  );

  // A load wins over any pending adjust, which stays held upstream.
  always_comb begin
    adjust_ready = (hold_q == '0) & ~set_valid & reset;
    accept       = adjust_valid & adjust_ready;

    adj_delta = '0;
    if (accept) begin
      adj_delta = (adjust_sign == ADJ_SIGN_MINUS) ? '1 : TIMER_WIDTH'(1);
    end

    time_d = time_q + step + adj_delta;
    hold_d = hold_q;
    if (accept) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_WIDTH'(1);
    end

    if (set_valid) begin
      time_d = set_time;
      hold_d = '0;
    end

    plus_d  = plus_q;
    minus_d = minus_q;
    if (accept && (adjust_sign == ADJ_SIGN_PLUS) && (plus_q != '1)) begin
      plus_d = plus_q + COUNT_WIDTH'(1);
    end
    if (accept && (adjust_sign == ADJ_SIGN_MINUS) && (minus_q != '1)) begin
      minus_d = minus_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      time_q  <= INIT_TIME;
      hold_q  <= '0;
      plus_q  <= '0;
      minus_q <= '0;
    end else begin
      time_q  <= time_d;
      hold_q  <= hold_d;
      plus_q  <= plus_d;
      minus_q <= minus_d;
    end
  end

  assign current_time       = time_q;
  assign adjust_plus_count  = plus_q;
  assign adjust_minus_count = minus_q;

endmodule

// File: tb/tb_jellyvl_synctimer_timer.sv
// Directed bench for jellyvl_synctimer_timer: three instances cover the default
// build, an adjust hold-off of 2, and an 8-bit timer with a non-zero INIT_TIME.
module tb_jellyvl_synctimer_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // instance a: defaults
  logic        reset_a = 1'b0, set_valid_a = 1'b0, sign_a = 1'b0, valid_a = 1'b0;
  logic [63:0] set_time_a = '0;
  logic        ready_a;
  logic [63:0] time_a;
  logic [15:0] plus_a, minus_a;

  // instance b: ADJUST_HOLD = 2
  logic        reset_b = 1'b0, set_valid_b = 1'b0, sign_b = 1'b0, valid_b = 1'b0;
  logic [63:0] set_time_b = '0;
  logic        ready_b;
  logic [63:0] time_b;
  logic [15:0] plus_b, minus_b;

  // instance c: TIMER_WIDTH = 8, INIT_TIME = 0x55
  logic        reset_c = 1'b0, set_valid_c = 1'b0, sign_c = 1'b0, valid_c = 1'b0;
  logic [7:0]  set_time_c = '0;
  logic        ready_c;
  logic [7:0]  time_c;
  logic [15:0] plus_c, minus_c;

  jellyvl_synctimer_timer dut_a (
    .reset(reset_a), .clk(clk), .set_time(set_time_a), .set_valid(set_valid_a),
    .adjust_sign(sign_a), .adjust_valid(valid_a), .adjust_ready(ready_a),
    .current_time(time_a), .adjust_plus_count(plus_a), .adjust_minus_count(minus_a)
  );

  jellyvl_synctimer_timer #(.ADJUST_HOLD(2)) dut_b (
    .reset(reset_b), .clk(clk), .set_time(set_time_b), .set_valid(set_valid_b),
    .adjust_sign(sign_b), .adjust_valid(valid_b), .adjust_ready(ready_b),
    .current_time(time_b), .adjust_plus_count(plus_b), .adjust_minus_count(minus_b)
  );

  jellyvl_synctimer_timer #(.TIMER_WIDTH(8), .INIT_TIME(8'h55)) dut_c (
    .reset(reset_c), .clk(clk), .set_time(set_time_c), .set_valid(set_valid_c),
    .adjust_sign(sign_c), .adjust_valid(valid_c), .adjust_ready(ready_c),
    .current_time(time_c), .adjust_plus_count(plus_c), .adjust_minus_count(minus_c)
  );

  // Outputs are sampled 1-2 time units after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [63:0] exp_free [6] = '{64'd3, 64'd6, 64'd10, 64'd13, 64'd16, 64'd20};

  initial begin
    tick(2);

    // reset state, instance a
    check("a_reset_time",  time_a,  64'd0);
    check("a_reset_ready", {63'd0, ready_a}, 64'd0);
    check("a_reset_plus",  {48'd0, plus_a},  64'd0);
    check("a_reset_minus", {48'd0, minus_a}, 64'd0);
    reset_a = 1'b1;
    #1;
    check("a_release_ready", {63'd0, ready_a}, 64'd1);
    check("a_release_time",  time_a, 64'd0);

    // free run 10/3
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check($sformatf("a_free_%0d", i), time_a, exp_free[i]);
    end
    tick(294);
    check("a_free_300", time_a, 64'd1000);

    // +1 adjust on a step-4 cycle, -1 adjust on a step-3 cycle
    tick(2);
    check("a_pre_adj", time_a, 64'd1006);
    valid_a = 1'b1;
    sign_a  = 1'b0;
    #1;
    check("a_adj_ready", {63'd0, ready_a}, 64'd1);
    tick(1);
    check("a_adj_plus_time", time_a, 64'd1011);
    sign_a = 1'b1;
    tick(1);
    check("a_adj_minus_time", time_a, 64'd1013);
    valid_a = 1'b0;
    check("a_plus_cnt",  {48'd0, plus_a},  64'd1);
    check("a_minus_cnt", {48'd0, minus_a}, 64'd1);

    // load collides with a pending adjust
    set_valid_a = 1'b1;
    set_time_a  = 64'h1234;
    valid_a     = 1'b1;
    sign_a      = 1'b0;
    #1;
    check("a_set_ready_low", {63'd0, ready_a}, 64'd0);
    tick(1);
    check("a_set_time", time_a, 64'h1234);
    check("a_set_plus_unchanged", {48'd0, plus_a}, 64'd1);
    set_valid_a = 1'b0;
    #1;
    check("a_post_set_ready", {63'd0, ready_a}, 64'd1);
    tick(1);
    check("a_post_set_adj", time_a, 64'h1238);
    check("a_post_set_plus", {48'd0, plus_a}, 64'd2);
    sign_a = 1'b1;
    tick(1);
    check("a_b2b_minus", time_a, 64'h123A);
    check("a_b2b_minus_cnt", {48'd0, minus_a}, 64'd2);
    valid_a = 1'b0;
    tick(1);
    check("a_frac_after_set", time_a, 64'h123E);

    // hold-off of 2 with adjust_valid held high
    reset_b = 1'b1;
    valid_b = 1'b1;
    sign_b  = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("b_ready_%0d", i), {63'd0, ready_b}, (i % 3 == 0) ? 64'd1 : 64'd0);
      tick(1);
    end
    check("b_time", time_b, 64'd37);
    check("b_plus_cnt", {48'd0, plus_b}, 64'd4);
    check("b_hold_ready", {63'd0, ready_b}, 64'd0);

    // reset in the middle of a hold
    reset_b = 1'b0;
    #1;
    check("b_rst_ready_now", {63'd0, ready_b}, 64'd0);
    tick(1);
    check("b_rst_time", time_b, 64'd0);
    check("b_rst_plus", {48'd0, plus_b}, 64'd0);
    check("b_rst_ready", {63'd0, ready_b}, 64'd0);
    tick(1);
    reset_b = 1'b1;
    valid_b = 1'b0;
    #1;
    check("b_rel_ready", {63'd0, ready_b}, 64'd1);
    check("b_rel_time", time_b, 64'd0);
    tick(1);
    check("b_rel_step", time_b, 64'd3);

    // 8-bit wrap after a load of 0xFE
    check("c_init_time", {56'd0, time_c}, 64'h55);
    reset_c     = 1'b1;
    set_valid_c = 1'b1;
    set_time_c  = 8'hFE;
    tick(1);
    set_valid_c = 1'b0;
    check("c_set_fe", {56'd0, time_c}, 64'hFE);
    tick(1);
    check("c_wrap_01", {56'd0, time_c}, 64'h01);
    tick(1);
    check("c_wrap_04", {56'd0, time_c}, 64'h04);
    tick(1);
    check("c_wrap_08", {56'd0, time_c}, 64'h08);

    // saturating statistics: 2^16 + 5 plus accepts
    valid_c = 1'b1;
    sign_c  = 1'b0;
    tick(65534);
    check("c_plus_fffe", {48'd0, plus_c}, 64'hFFFE);
    tick(1);
    check("c_plus_ffff", {48'd0, plus_c}, 64'hFFFF);
    tick(6);
    check("c_plus_sat", {48'd0, plus_c}, 64'hFFFF);
    sign_c = 1'b1;
    tick(3);
    check("c_minus_cnt", {48'd0, minus_c}, 64'd3);
    check("c_plus_hold", {48'd0, plus_c}, 64'hFFFF);
    valid_c = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
